lcd_timing: RTL and testbench

LCD_TIMING -- requirements
Module: lcd_timing

---
 rtl/lcd_timing.sv | 186 ++++++++++++++++++
 tb/tb_lcd_timing.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/lcd_timing.sv
// lcd_timing: scanline / frame timing generator for a 2-bit-per-pixel LCD.
// It paces a pixel source through OAM, transfer, hblank and vblank periods and
// produces the line counter, the LY compare and the vblank / stat interrupts.
module lcd_timing #(
    parameter int LINE_CLKS = 456,
    parameter int OAM_CLKS  = 80,
    parameter int H         = 160,
    parameter int V         = 144,
    parameter int LINES     = 154
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    input  logic       lcd_on,
    input  logic [1:0] pix_data,
    input  logic       pix_valid,
    output logic       pix_ready,
    output logic       lcd_clkena,
    output logic [1:0] lcd_data,
    output logic [1:0] mode,
    output logic [7:0] ly,
    input  logic [7:0] lyc,
    input  logic [3:0] stat_en,
    output logic       lyc_match,
    output logic       irq_vblank,
    output logic       irq_stat,
    output logic       underrun
);

    localparam int DOT_W = $clog2(LINE_CLKS);

    localparam logic [DOT_W-1:0] DOT_LAST = DOT_W'(LINE_CLKS - 1);
    localparam logic [DOT_W-1:0] OAM_LAST = DOT_W'(OAM_CLKS - 1);
    localparam logic [7:0]       X_LAST   = 8'(H - 1);
    localparam logic [7:0]       V_L      = 8'(V);
    localparam logic [7:0]       LY_LAST  = 8'(LINES - 1);

    localparam logic [1:0] MODE_HBLANK = 2'b00;
    localparam logic [1:0] MODE_VBLANK = 2'b01;
    localparam logic [1:0] MODE_OAM    = 2'b10;
    localparam logic [1:0] MODE_XFER   = 2'b11;

    typedef enum logic [2:0] {
        S_OFF,
        S_OAM,
        S_XFER,
        S_HBLANK,
        S_VBLANK
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [DOT_W-1:0] dot;
    logic [DOT_W-1:0] dot_n;
    logic [7:0]       x;
    logic [7:0]       x_n;
    logic [7:0]       ly_n;
    logic [7:0]       ly_inc;
    logic [1:0]       mode_n;
    logic             line_end;
    logic             strobe_n;
    logic             vblank_n;
    logic             underrun_n;
    logic             lyc_n;
    logic             stat_n;
    logic             stat_q;

    // The pixel source may only hand over pixels while the line is in transfer.
    assign pix_ready = (state == S_XFER);

    // Next-state, counters and next-output decode; every output is registered from these.
    always_comb begin
        state_n    = state;
        mode_n     = mode;
        dot_n      = dot;
        ly_n       = ly;
        x_n        = x;
        strobe_n   = 1'b0;
        vblank_n   = 1'b0;
        underrun_n = 1'b0;
        line_end   = (dot == DOT_LAST);
        ly_inc     = (ly == LY_LAST) ? 8'd0 : ly + 8'd1;

        if (!lcd_on) begin
            // Display off wins over everything, independent of ce.
            state_n = S_OFF;
            mode_n  = MODE_HBLANK;
            dot_n   = '0;
            ly_n    = '0;
            x_n     = '0;
        end else if (ce) begin
            dot_n = line_end ? '0 : dot + DOT_W'(1);

            unique case (state)
                S_OFF: begin
                    // The wake-up ce only arms the first line; dot 0 is consumed by the next ce.
                    state_n = S_OAM;
                    mode_n  = MODE_OAM;
                    dot_n   = '0;
                    ly_n    = '0;
                    x_n     = '0;
                end
                S_OAM: begin
                    if (dot == OAM_LAST) begin
                        state_n = S_XFER;
                        mode_n  = MODE_XFER;
                    end
                end
                S_XFER: begin
                    if (pix_valid) begin
                        strobe_n = 1'b1;
                        if (x == X_LAST) begin
                            state_n = S_HBLANK;
                            mode_n  = MODE_HBLANK;
                            x_n     = '0;
                        end else begin
                            x_n = x + 8'd1;
                        end
                    end
                end
                S_HBLANK, S_VBLANK: begin
                end
                default: begin
                    state_n = S_OFF;
                    mode_n  = MODE_HBLANK;
                end
            endcase

            // Scanline boundary: any still-open transfer is abandoned and flagged.
            if (line_end && state != S_OFF) begin
                underrun_n = (state == S_XFER) && (state_n == S_XFER);
                dot_n      = '0;
                x_n        = '0;
                ly_n       = ly_inc;
                if (ly_inc < V_L) begin
                    state_n = S_OAM;
                    mode_n  = MODE_OAM;
                end else begin
                    state_n  = S_VBLANK;
                    mode_n   = MODE_VBLANK;
                    vblank_n = (state != S_VBLANK);
                end
            end
        end

        lyc_n  = (state_n != S_OFF) && (ly_n == lyc);
        stat_n = (stat_en[0] && (mode_n == MODE_HBLANK)) ||
                 (stat_en[1] && (mode_n == MODE_VBLANK)) ||
                 (stat_en[2] && (mode_n == MODE_OAM))    ||
                 (stat_en[3] && lyc_n);
    end

    // Register state, counters, pixel strobe and interrupt pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_OFF;
            mode       <= MODE_HBLANK;
            dot        <= '0;
            ly         <= '0;
            x          <= '0;
            lcd_clkena <= 1'b0;
            lcd_data   <= 2'b00;
            lyc_match  <= 1'b0;
            irq_vblank <= 1'b0;
            irq_stat   <= 1'b0;
            underrun   <= 1'b0;
            stat_q     <= 1'b0;
        end else begin
            state      <= state_n;
            mode       <= mode_n;
            dot        <= dot_n;
            ly         <= ly_n;
            x          <= x_n;
            lcd_clkena <= strobe_n;
            if (strobe_n) begin
                lcd_data <= pix_data;
            end
            lyc_match  <= lyc_n;
            irq_vblank <= vblank_n;
            irq_stat   <= stat_n && !stat_q;
            underrun   <= underrun_n;
            stat_q     <= stat_n;
        end
    end

endmodule

// File: tb/tb_lcd_timing.sv
// tb_lcd_timing: randomized bench for lcd_timing with a position-based reference
// model (frame position -> mode) and a pixel scoreboard drained by a monitor.
module tb_lcd_timing;

    localparam int LC = 60;
    localparam int OC = 10;
    localparam int HP = 20;
    localparam int VP = 8;
    localparam int LN = 11;
    localparam int NCYC = 6000;

    logic       clk = 1'b0;
    logic       reset;
    logic       ce;
    logic       lcd_on;
    logic [1:0] pix_data;
    logic       pix_valid;
    logic       pix_ready;
    logic       lcd_clkena;
    logic [1:0] lcd_data;
    logic [1:0] mode;
    logic [7:0] ly;
    logic [7:0] lyc;
    logic [3:0] stat_en;
    logic       lyc_match;
    logic       irq_vblank;
    logic       irq_stat;
    logic       underrun;

    int tests = 0;
    int fails = 0;

    // reference model: position in frame plus pixels taken this line
    int   m_run, m_ly, m_dot, m_px;
    bit   m_prev_stat;
    logic [1:0] e_mode;
    logic [7:0] e_ly;
    logic e_ready, e_strobe, e_lyc, e_vbl, e_irqs, e_und;
    logic [1:0] exp_q[$];

    lcd_timing #(
        .LINE_CLKS(LC), .OAM_CLKS(OC), .H(HP), .V(VP), .LINES(LN)
    ) dut (
        .clk(clk), .reset(reset), .ce(ce), .lcd_on(lcd_on),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .lcd_clkena(lcd_clkena), .lcd_data(lcd_data), .mode(mode), .ly(ly),
        .lyc(lyc), .stat_en(stat_en), .lyc_match(lyc_match),
        .irq_vblank(irq_vblank), .irq_stat(irq_stat), .underrun(underrun)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] mode_of(input int run, input int l, input int d, input int p);
        if (run == 0) return 2'b00;
        if (l >= VP) return 2'b01;
        if (d < OC) return 2'b10;
        if (p < HP) return 2'b11;
        return 2'b00;
    endfunction

    task automatic model_outputs();
        bit st;
        e_mode  = mode_of(m_run, m_ly, m_dot, m_px);
        e_ly    = 8'(m_ly);
        e_ready = (e_mode == 2'b11);
        e_lyc   = (m_run != 0) && (m_ly == int'(lyc));
        st = (stat_en[0] && e_mode == 2'b00) || (stat_en[1] && e_mode == 2'b01) ||
             (stat_en[2] && e_mode == 2'b10) || (stat_en[3] && e_lyc);
        e_irqs = st && !m_prev_stat;
        m_prev_stat = st;
    endtask

    task automatic model_reset();
        m_run = 0; m_ly = 0; m_dot = 0; m_px = 0; m_prev_stat = 0;
        e_mode = 2'b00; e_ly = 8'd0; e_ready = 0; e_strobe = 0;
        e_lyc = 0; e_vbl = 0; e_irqs = 0; e_und = 0;
        exp_q.delete();
    endtask

    // advance the model across one clock edge with the inputs currently driven
    task automatic model_step();
        logic [1:0] cur;
        e_strobe = 0; e_vbl = 0; e_und = 0;
        if (!lcd_on) begin
            m_run = 0; m_ly = 0; m_dot = 0; m_px = 0;
        end else if (ce) begin
            if (m_run == 0) begin
                m_run = 1; m_ly = 0; m_dot = 0; m_px = 0;
            end else begin
                cur = mode_of(m_run, m_ly, m_dot, m_px);
                if (cur == 2'b11 && pix_valid) begin
                    exp_q.push_back(pix_data);
                    e_strobe = 1;
                    m_px++;
                end
                if (m_dot == LC - 1) begin
                    if (cur == 2'b11 && m_px < HP) e_und = 1;
                    m_dot = 0;
                    m_px  = 0;
                    m_ly  = (m_ly + 1) % LN;
                    if (m_ly == VP) e_vbl = 1;
                end else begin
                    m_dot++;
                end
            end
        end
        model_outputs();
    endtask

    task automatic check_outputs(input string name, input int cyc);
        logic [15:0] act, want;
        act  = {mode, ly, pix_ready, lcd_clkena, lyc_match, irq_vblank, irq_stat, underrun};
        want = {e_mode, e_ly, e_ready, e_strobe, e_lyc, e_vbl, e_irqs, e_und};
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s cyc=%0d got mode=%b ly=%0d rdy=%b stb=%b lycm=%b vbl=%b stat=%b und=%b want mode=%b ly=%0d rdy=%b stb=%b lycm=%b vbl=%b stat=%b und=%b",
                     name, cyc, mode, ly, pix_ready, lcd_clkena, lyc_match, irq_vblank, irq_stat, underrun,
                     e_mode, e_ly, e_ready, e_strobe, e_lyc, e_vbl, e_irqs, e_und);
        end
    endtask

    task automatic check_data_zero(input string name);
        tests++;
        if (lcd_data !== 2'b00) begin
            fails++;
            $display("FAIL %s lcd_data got %b want 00", name, lcd_data);
        end
    endtask

    // monitor: every strobe must carry the oldest pixel the model accepted
    initial begin
        logic [1:0] d;
        forever begin
            @(negedge clk);
            if (lcd_clkena === 1'b1) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL pixel strobe with nothing pending, lcd_data=%b", lcd_data);
                end else begin
                    d = exp_q.pop_front();
                    if (lcd_data !== d) begin
                        fails++;
                        $display("FAIL pixel lcd_data got %b want %b", lcd_data, d);
                    end
                end
            end
        end
    end

    initial begin
        int vmode;
        int off_cnt;
        bit did_drop;
        int r;
        reset = 1'b1; ce = 1'b0; lcd_on = 1'b0; pix_data = 2'b00;
        pix_valid = 1'b0; lyc = 8'd3; stat_en = 4'b1000;
        vmode = 0; off_cnt = 0; did_drop = 0;
        model_reset();
        @(negedge clk); #1;
        check_outputs("reset", 0);
        check_data_zero("reset");
        reset = 1'b0;

        for (int cyc = 1; cyc <= NCYC; cyc++) begin
            if (cyc == 2000 || (cyc > 2500 && $urandom_range(0, 1499) == 0)) begin
                reset = 1'b1;
                #1;
                model_reset();
                check_outputs("async_reset", cyc);
                check_data_zero("async_reset");
                @(negedge clk); #1;
                check_outputs("reset_hold", cyc);
                reset = 1'b0;
                continue;
            end

            if (off_cnt > 0) begin
                lcd_on = 1'b0;
                off_cnt--;
            end else begin
                lcd_on = 1'b1;
                if (!did_drop && cyc > 3000 && e_mode == 2'b11) begin
                    did_drop = 1;
                    off_cnt = 1;
                end else if ($urandom_range(0, 699) == 0) begin
                    off_cnt = $urandom_range(1, 4);
                end
            end

            ce = (cyc < 1500) ? 1'b1 : ($urandom_range(0, 3) != 0);

            if (m_dot == 0) begin
                r = $urandom_range(0, 19);
                vmode = (cyc < 700) ? 0 : (r < 10) ? 0 : (r < 17) ? 1 : 2;
            end
            pix_valid = (vmode == 0) ? 1'b1 : (vmode == 1) ? ($urandom_range(0, 3) != 0) : 1'b0;
            pix_data  = 2'($urandom_range(0, 3));

            if ($urandom_range(0, 199) == 0) lyc = 8'($urandom_range(0, LN));
            if ($urandom_range(0, 299) == 0) stat_en = 4'($urandom_range(0, 15));

            model_step();
            @(negedge clk); #1;
            check_outputs("cycle", cyc);
        end

        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL pending_pixels got %0d left want 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
